// File: rtl/r5fp_retire_pkg.sv
// rtl/r5fp_retire_pkg.sv - shared fflag indices, entry type and status/NaN helpers for FMA retire
package r5fp_retire_pkg;

  localparam int FF_NX = 0;
  localparam int FF_UF = 1;
  localparam int FF_OF = 2;
  localparam int FF_DZ = 3;
  localparam int FF_NV = 4;

  // zStatus bit positions produced by the R5FP datapath
  localparam int Z_INVALID = 2;
  localparam int Z_TINY    = 3;
  localparam int Z_HUGE    = 4;
  localparam int Z_INEXACT = 5;

  typedef struct packed {
    logic [31:0] z;
    logic [4:0]  flags;
    logic [4:0]  tag;
  } retire_entry_t;

  function automatic logic [4:0] to_rv_flags(input logic [7:0] status);
    logic [4:0] f;
    f         = '0;
    f[FF_NV]  = status[Z_INVALID];
    f[FF_DZ]  = 1'b0;
    f[FF_OF]  = status[Z_HUGE];
    f[FF_UF]  = status[Z_TINY] & status[Z_INEXACT];
    f[FF_NX]  = status[Z_INEXACT];
    return f;
  endfunction

  // Operates on a zero-extended encoding so FP32 and FP64 builds share one helper.
  function automatic logic [63:0] canon_nan(input logic [63:0] z, input int expW, input int sigW);
    logic [63:0] sigMask;
    logic [63:0] expMask;
    sigMask = (64'd1 << sigW) - 64'd1;
    expMask = ((64'd1 << expW) - 64'd1) << sigW;
    if (((z & expMask) == expMask) && ((z & sigMask) != 64'd0))
      return expMask | (64'd1 << (sigW - 1));
    return z;
  endfunction

endpackage

// File: rtl/r5fp_retire_fifo.sv
// rtl/r5fp_retire_fifo.sv - register FIFO of retire entries with push, pop and flush
module r5fp_retire_fifo
  import r5fp_retire_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = retire_entry_t
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  entry_t pushData,
  input  logic   pop,
  input  logic   flush,
  output entry_t headData,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [CNT_W-1:0]   count;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign headData = mem[rdPtr];

  // The parent only pushes when space exists (or a pop frees it) and only pops when non-empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (pop) rdPtr <= rdPtr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/r5fp_fma_retire.sv
// rtl/r5fp_fma_retire.sv - FMA retire stage: NaN canonicalisation, fflags conversion, result FIFO, sticky fflags CSR
module r5fp_fma_retire
  import r5fp_retire_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int SIG_W = 23,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+SIG_W:0]   in_z,
  input  logic [7:0]             in_status,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+SIG_W:0]   out_z,
  output logic [4:0]             out_flags,
  output logic [TAG_W-1:0]       out_tag,
  input  logic                   flush,
  input  logic                   fflags_we,
  input  logic [4:0]             fflags_wdata,
  output logic [4:0]             fflags
);

  localparam int Z_W = EXP_W + SIG_W + 1;

  typedef struct packed {
    logic [Z_W-1:0]   z;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t inEntry;
  entry_t headEntry;
  logic   full;
  logic   empty;
  logic   commit;
  logic   push;

  always_comb begin
    inEntry       = '0;
    inEntry.z     = Z_W'(canon_nan(64'(in_z), EXP_W, SIG_W));
    inEntry.flags = to_rv_flags(in_status);
    inEntry.tag   = in_tag;
  end

  assign out_valid = !empty;
  assign commit    = out_valid & out_ready;
  assign in_ready  = !full | commit;
  // A push coinciding with flush is discarded inside the FIFO.
  assign push      = in_valid & in_ready;

  r5fp_retire_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pushData (inEntry),
    .pop      (commit),
    .flush    (flush),
    .headData (headEntry),
    .full     (full),
    .empty    (empty)
  );

  assign out_z     = headEntry.z;
  assign out_flags = headEntry.flags;
  assign out_tag   = headEntry.tag;

  // A retiring op still contributes its flags even when software writes the CSR that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       fflags <= '0;
    else if (fflags_we) fflags <= fflags_wdata | (commit ? headEntry.flags : 5'd0);
    else if (commit)    fflags <= fflags | headEntry.flags;
  end

endmodule

// File: tb/tb_r5fp_fma_retire.sv
// tb/tb_r5fp_fma_retire.sv - scoreboard bench for r5fp_fma_retire (FP32, DEPTH 2)
module tb_r5fp_fma_retire;
  import r5fp_retire_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        fflags_we = 1'b0;
  logic [31:0] in_z = '0;
  logic [7:0]  in_status = '0;
  logic [4:0]  in_tag = '0;
  logic [4:0]  fflags_wdata = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_z;
  logic [4:0]  out_flags;
  logic [4:0]  out_tag;
  logic [4:0]  fflags;

  retire_entry_t expQ[$];
  retire_entry_t nextExp;
  retire_entry_t monE;
  int nVec = 0;
  int nMis = 0;

  r5fp_fma_retire dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_z         (in_z),
    .in_status    (in_status),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_z        (out_z),
    .out_flags    (out_flags),
    .out_tag      (out_tag),
    .flush        (flush),
    .fflags_we    (fflags_we),
    .fflags_wdata (fflags_wdata),
    .fflags       (fflags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] z, input logic [7:0] st, input logic [4:0] tag,
                       input logic [31:0] ez, input logic [4:0] ef);
    in_valid  = 1'b1;
    in_z      = z;
    in_status = st;
    in_tag    = tag;
    nextExp   = '{z: ez, flags: ef, tag: tag};
  endtask

  task automatic drain;
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((out_valid || expQ.size() != 0) && n < 50) begin
      tick;
      n++;
    end
    check("drain_bound", 32'(n < 50), 32'd1);
  endtask

  task automatic csrWrite(input logic [4:0] v);
    fflags_we    = 1'b1;
    fflags_wdata = v;
    tick;
    fflags_we    = 1'b0;
  endtask

  // Monitor: compares the head on each commit, then records accepted inputs.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          nVec++;
          nMis++;
          $display("FAIL unexpected_output: got tag %h z %h expected none", out_tag, out_z);
        end else begin
          monE = expQ.pop_front();
          check("out_z", out_z, monE.z);
          check("out_flags", 32'(out_flags), 32'(monE.flags));
          check("out_tag", 32'(out_tag), 32'(monE.tag));
        end
      end
      if (in_valid && in_ready && !flush) expQ.push_back(nextExp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_fflags", 32'(fflags), 32'd0);
    check("rst_out_z", out_z, 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick;

    // Single op, one-cycle latency
    out_ready = 1'b1;
    drive(32'h40490FDB, 8'h20, 5'd3, 32'h40490FDB, 5'b00001);
    tick;
    in_valid = 1'b0;
    check("t1_latency_valid", 32'(out_valid), 32'd1);
    tick;
    check("t1_fflags", 32'(fflags), 32'b00001);

    // NaN canonicalisation
    drive(32'hFFA00001, 8'h04, 5'd9, 32'h7FC00000, 5'b10000);
    tick;
    drain;
    check("t2_fflags", 32'(fflags), 32'b10001);

    // Backpressure: third op held until the head drains
    out_ready = 1'b0;
    drive(32'h3F800000, 8'h08, 5'd1, 32'h3F800000, 5'b00000);
    tick;
    drive(32'h40000000, 8'h30, 5'd2, 32'h40000000, 5'b00101);
    tick;
    drive(32'h40400000, 8'h28, 5'd3, 32'h40400000, 5'b00011);
    check("t3_in_ready_full", 32'(in_ready), 32'd0);
    tick;
    tick;
    check("t3_hold_valid", 32'(out_valid), 32'd1);
    check("t3_hold_z", out_z, 32'h3F800000);
    check("t3_hold_tag", 32'(out_tag), 32'd1);
    check("t3_in_ready_held", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check("t3_in_ready_pop", 32'(in_ready), 32'd1);
    tick;
    drain;
    check("t3_fflags", 32'(fflags), 32'b10111);

    // Full FIFO with push and pop every cycle across pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(32'h41000000 + 32'(i), 8'h00, 5'(4 + i), 32'h41000000 + 32'(i), 5'b00000);
      tick;
    end
    out_ready = 1'b1;
    for (int i = 2; i < 10; i++) begin
      drive(32'h41000000 + 32'(i), 8'h00, 5'(4 + i), 32'h41000000 + 32'(i), 5'b00000);
      #1;
      check("t4_in_ready", 32'(in_ready), 32'd1);
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("t4_still_full", 32'(in_ready), 32'd0);
    check("t4_valid", 32'(out_valid), 32'd1);
    drain;

    // CSR write coinciding with a commit
    csrWrite(5'b00100);
    check("t5_csr", 32'(fflags), 32'b00100);
    out_ready = 1'b0;
    drive(32'h3F000000, 8'h28, 5'd7, 32'h3F000000, 5'b00011);
    tick;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    fflags_we    = 1'b1;
    fflags_wdata = 5'b00000;
    tick;
    fflags_we = 1'b0;
    check("t5_fflags", 32'(fflags), 32'b00011);

    // Flush of a full FIFO with a source presenting an op
    csrWrite(5'b00000);
    out_ready = 1'b0;
    drive(32'hC0000000, 8'h04, 5'd10, 32'hC0000000, 5'b10000);
    tick;
    drive(32'hC0400000, 8'h04, 5'd11, 32'hC0400000, 5'b10000);
    tick;
    drive(32'h42000000, 8'h00, 5'd12, 32'h42000000, 5'b00000);
    flush = 1'b1;
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    expQ.delete();
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    check("t6_fflags", 32'(fflags), 32'd0);
    tick;
    tick;
    check("t6_no_ghost", 32'(out_valid), 32'd0);

    // Flush drops a push that would otherwise be accepted
    drive(32'h42400000, 8'h00, 5'd13, 32'h42400000, 5'b00000);
    tick;
    drive(32'h42800000, 8'h00, 5'd14, 32'h42800000, 5'b00000);
    flush = 1'b1;
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    expQ.delete();
    check("t6b_valid", 32'(out_valid), 32'd0);
    tick;
    check("t6b_no_ghost", 32'(out_valid), 32'd0);

    // Commit in the flush cycle still retires its flags
    drive(32'hBF800000, 8'h04, 5'd15, 32'hBF800000, 5'b10000);
    tick;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick;
    flush = 1'b0;
    expQ.delete();
    check("t6c_fflags", 32'(fflags), 32'b10000);
    check("t6c_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream
    csrWrite(5'b11111);
    out_ready = 1'b0;
    drive(32'h43000000, 8'h20, 5'd16, 32'h43000000, 5'b00001);
    tick;
    drive(32'h43400000, 8'h20, 5'd17, 32'h43400000, 5'b00001);
    #2;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t7_valid", 32'(out_valid), 32'd0);
    check("t7_fflags", 32'(fflags), 32'd0);
    check("t7_in_ready", 32'(in_ready), 32'd1);
    check("t7_out_z", out_z, 32'd0);
    expQ.delete();
    tick;
    reset_n = 1'b1;
    tick;
    out_ready = 1'b1;
    drive(32'h3E800000, 8'h10, 5'd18, 32'h3E800000, 5'b00100);
    tick;
    drain;
    check("t7_recover_fflags", 32'(fflags), 32'b00100);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/r5fp_fma_retire.md
Name: r5fp_fma_retire

Overview:
- Sequential stage directly downstream of the R5FP fused multiply-add datapath (mul, acc, postproc, exp_decr).
- Accepts one MAC result per cycle: z, 8-bit zStatus, tag.
- Canonicalises NaNs and converts zStatus to 5-bit RISC-V fflags.
- Buffers results in a small FIFO with valid/ready handshake toward writeback.
- Accumulates the sticky fflags CSR value at commit time.

Parameters:
EXP_W, 8, exponent width (11 for FP64 builds)
SIG_W, 23, stored significand width (52 for FP64 builds)
TAG_W, 5, destination tag width carried alongside each result
DEPTH, 2, result FIFO entries (power of two, ≥2)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  MAC result valid
in_ready  out  1  stage can accept a result this cycle
in_z  in  EXP_W+SIG_W+1  MAC result {sign,exp,sig}
in_status  in  8  MAC zStatus, R5FP_inc.vh `Z_* bit positions
in_tag  in  TAG_W  destination tag
out_valid  out  1  head entry valid
out_ready  in  1  writeback consumes head
out_z  out  EXP_W+SIG_W+1  canonicalised result
out_flags  out  5  per-op fflags {NV,DZ,OF,UF,NX}
out_tag  out  TAG_W  tag of head
flush  in  1  discard all buffered entries
fflags_we  in  1  CSR write of fflags
fflags_wdata  in  5  CSR write data
fflags  out  5  accumulated sticky fflags

Behaviour:
- Reset (async assert, sync deassert outside the block): FIFO empty, out_valid=0, out_z=0, out_flags=0, out_tag=0, fflags=0, in_ready=1.
- Conversion, combinational at input, stored per entry:
  - NV=`Z_INVALID
  - DZ=0 (FMA never divides)
  - OF=`Z_HUGE
  - UF=`Z_TINY & `Z_INEXACT
  - NX=`Z_INEXACT
- NaN canonicalisation: if exp all ones and sig≠0, store sign=0, exp all ones, sig MSB=1, other sig bits 0 (FP32 0x7FC00000). All other encodings pass unchanged.
- Accept when in_valid & in_ready.
- Latency: accepted result is visible at out_* the next cycle (registered FIFO, no bypass).
- Commit when out_valid & out_ready; the head pops the same edge.
- in_ready = !full | (out_valid & out_ready). Push and pop in the same cycle are allowed when full or empty. Count is unchanged on simultaneous push+pop.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits. Full = count==DEPTH; empty = count==0.
- out_* hold stable while out_valid & !out_ready.
- fflags next value:
  - fflags_we=1: fflags_wdata | (commit ? head flags : 0)
  - else commit: fflags | head flags
  - else: hold
- flush: count←0, pointers←0, out_valid←0 next cycle.
  - Any push in the flush cycle is dropped.
  - A commit in the flush cycle still ORs its flags into fflags (the op retired).
  - Flushed entries never touch fflags.
  - in_ready is unaffected by flush.
- out_* data registers are not cleared on flush, only invalidated. Bench must check them only when out_valid=1.
- reset_n assertion mid-operation: immediate return to reset values regardless of handshake state.

Decomposition:
- Package r5fp_retire_pkg:
  - fflag bit index constants FF_NX=0, FF_UF=1, FF_OF=2, FF_DZ=3, FF_NV=4
  - typedef retire_entry_t {z, flags, tag}
  - function to_rv_flags(status) implementing the mapping above, shared with testbenches
  - function canon_nan(z)
- Sub-module r5fp_retire_fifo: parameterised DEPTH×entry register FIFO with push/pop/flush/count.
- Top handles conversion, fflags CSR logic and handshake glue.

Test Plan:
- Single op, no backpressure: in_z=0x40490FDB, in_status with `Z_INEXACT only, tag 3 → next cycle out_valid=1, out_z=0x40490FDB, out_flags=5'b00001, out_tag=3; fflags=00001 after commit.
- NaN canonicalise: in_z=0xFFA00001, `Z_INVALID set → out_z=0x7FC00000, out_flags=10000, fflags NV set after commit.
- Backpressure: out_ready=0, push 3 ops back-to-back → in_ready drops after 2 accepts. Third op held by source. out_* stable. Releasing out_ready drains in order, tags 1,2,3.
- Simultaneous push+pop when full → count stays 2, no loss, order preserved across pointer wrap over 10 ops.
- CSR write during commit: fflags=00100, fflags_we=1, wdata=00000, committing op with flags 00011 → fflags=00011.
- Flush with 2 entries of flags 10000 and a concurrent push → FIFO empty next cycle. fflags unchanged. Pushed op never appears. Asserting reset_n low mid-stream clears fflags and out_valid immediately.
